// File: rtl/mov_pkg.sv
// Shared types and helpers for the move-execution unit.
package mov_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    MOVI_Z = 2'd0,
    MOVI_S = 2'd1,
    MOV_R  = 2'd2,
    RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    XFER,
    FIN,
    ERR
  } state_e;

  // Widens an imm_w-bit immediate; bits above imm_w copy the top bit when signed.
  function automatic logic [MAX_W-1:0] ext_imm(input logic [MAX_W-1:0] imm,
                                               input int imm_w,
                                               input logic is_signed);
    logic [MAX_W-1:0] res;
    logic             fill;
    res  = '0;
    fill = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < imm_w) begin
        res[i] = imm[i];
        fill   = is_signed & imm[i];
      end else begin
        res[i] = fill;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mov_sel_decode.sv
// Turns a register selector into a one-hot enable, a P0 flag and a legality flag.
module mov_sel_decode #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 6,
  parameter int P0_SEL   = 4,
  parameter bit ALLOW_P0 = 1'b1
) (
  input  logic [SEL_W-1:0]    sel_i,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                p0_o,
  output logic                legal_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_i == SEL_W'(i)) onehot_o[i] = 1'b1;
    end
    p0_o    = ALLOW_P0 && (sel_i == SEL_W'(P0_SEL));
    legal_o = (|onehot_o) | p0_o;
  end

endmodule

// File: rtl/mov_exec.sv
// Move-execution FSM: captures a decoded move, checks its operands and
// sequences bus drive, source read and destination write, then reports done.
module mov_exec
  import mov_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int IMM_W    = 6,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 6,
  parameter int P0_SEL   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    dst_sel,
  input  logic [SEL_W-1:0]    src_sel,
  input  logic [IMM_W-1:0]    imm,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_oe,
  output logic [NUM_REGS-1:0] reg_rd_en,
  output logic [NUM_REGS-1:0] reg_wr_en,
  output logic                p0_wr_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q;
  mode_e               mode_q;
  logic [SEL_W-1:0]    dstSel_q;
  logic [SEL_W-1:0]    srcSel_q;
  logic [IMM_W-1:0]    imm_q;

  logic [DATA_W-1:0]   busOut_q;
  logic                busOe_q;
  logic [NUM_REGS-1:0] rdEn_q;
  logic [NUM_REGS-1:0] wrEn_q;
  logic                p0Wr_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [NUM_REGS-1:0] dstOneHot;
  logic                dstIsP0;
  logic                dstLegal;
  logic [NUM_REGS-1:0] srcOneHot;
  logic                srcIsP0;
  logic                srcLegal;
  logic                illegal;
  logic [DATA_W-1:0]   immExt;

  mov_sel_decode #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .P0_SEL   (P0_SEL),
    .ALLOW_P0 (1'b1)
  ) u_dst_decode (
    .sel_i    (dstSel_q),
    .onehot_o (dstOneHot),
    .p0_o     (dstIsP0),
    .legal_o  (dstLegal)
  );

  // P0 is write-only, so the source decoder never recognises it.
  mov_sel_decode #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .P0_SEL   (P0_SEL),
    .ALLOW_P0 (1'b0)
  ) u_src_decode (
    .sel_i    (srcSel_q),
    .onehot_o (srcOneHot),
    .p0_o     (srcIsP0),
    .legal_o  (srcLegal)
  );

  assign illegal = (mode_q == RSVD) || !dstLegal ||
                   ((mode_q == MOV_R) && (!srcLegal || srcIsP0));

  assign immExt = DATA_W'(ext_imm(MAX_W'(imm_q), IMM_W, mode_q == MOVI_S));

  // Outputs are registered alongside the state so each one is a pure
  // function of the state being entered and the captured operands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      mode_q   <= MOVI_Z;
      dstSel_q <= '0;
      srcSel_q <= '0;
      imm_q    <= '0;
      busOut_q <= '0;
      busOe_q  <= 1'b0;
      rdEn_q   <= '0;
      wrEn_q   <= '0;
      p0Wr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      busOut_q <= '0;
      busOe_q  <= 1'b0;
      rdEn_q   <= '0;
      wrEn_q   <= '0;
      p0Wr_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              mode_q   <= mode_e'(mode);
              dstSel_q <= dst_sel;
              srcSel_q <= src_sel;
              imm_q    <= imm;
              state_q  <= DECODE;
              busy_q   <= 1'b1;
            end
          end
          DECODE: begin
            if (illegal) begin
              state_q <= ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= XFER;
              wrEn_q  <= dstOneHot;
              p0Wr_q  <= dstIsP0;
              if (mode_q == MOV_R) begin
                rdEn_q <= srcOneHot;
              end else begin
                busOe_q  <= 1'b1;
                busOut_q <= immExt;
              end
            end
          end
          XFER: begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
          FIN, ERR: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus_out   = busOut_q;
  assign bus_oe    = busOe_q;
  assign reg_rd_en = rdEn_q;
  assign reg_wr_en = wrEn_q;
  assign p0_wr_en  = p0Wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mov_exec.sv
// Randomised self-checking bench for mov_exec against a per-cycle timeline model.
module tb_mov_exec;

  localparam int DATA_W   = 16;
  localparam int IMM_W    = 6;
  localparam int NUM_REGS = 4;
  localparam int SEL_W    = 6;
  localparam int P0_SEL   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                start;
  logic [1:0]          mode;
  logic [SEL_W-1:0]    dst_sel;
  logic [SEL_W-1:0]    src_sel;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   bus_out;
  logic                bus_oe;
  logic [NUM_REGS-1:0] reg_rd_en;
  logic [NUM_REGS-1:0] reg_wr_en;
  logic                p0_wr_en;
  logic                busy;
  logic                done;
  logic                err;

  int vecCount = 0;
  int errCount = 0;
  int opCount  = 0;

  mov_exec #(
    .DATA_W   (DATA_W),
    .IMM_W    (IMM_W),
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .P0_SEL   (P0_SEL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .mode      (mode),
    .dst_sel   (dst_sel),
    .src_sel   (src_sel),
    .imm       (imm),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .reg_rd_en (reg_rd_en),
    .reg_wr_en (reg_wr_en),
    .p0_wr_en  (p0_wr_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Packed layout: {busy, done, err, bus_oe, p0_wr_en, reg_wr_en, reg_rd_en, bus_out}
  function automatic logic [28:0] obsVec();
    return {busy, done, err, bus_oe, p0_wr_en, reg_wr_en, reg_rd_en, bus_out};
  endfunction

  function automatic bit isLegal(input int md, input int dst, input int src);
    if (md == 3) return 1'b0;
    if (!(dst < NUM_REGS || dst == P0_SEL)) return 1'b0;
    if (md == 2 && src >= NUM_REGS) return 1'b0;
    return 1'b1;
  endfunction

  // Expected outputs c cycles after the start was captured.
  function automatic logic [28:0] expOut(input int md, input int dst, input int src,
                                         input int immV, input int c);
    logic       b, d, e, oe, p0;
    logic [3:0] wr, rd;
    logic [15:0] bus;
    b = 0; d = 0; e = 0; oe = 0; p0 = 0; wr = 0; rd = 0; bus = 0;
    if (!isLegal(md, dst, src)) begin
      if (c == 1) b = 1;
      if (c == 2) begin b = 1; d = 1; e = 1; end
    end else begin
      if (c == 1) b = 1;
      if (c == 2) begin
        b = 1;
        if (dst == P0_SEL) p0 = 1;
        else wr = 4'(1 << dst);
        if (md == 2) rd = 4'(1 << src);
        else begin
          oe = 1;
          if (md == 1 && immV >= 32) bus = 16'(immV + 65536 - 64);
          else bus = 16'(immV);
        end
      end
      if (c == 3) begin b = 1; d = 1; end
    end
    return {b, d, e, oe, p0, wr, rd, bus};
  endfunction

  task automatic checkOutput(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one move; abortAt>0 aborts in that cycle (kind 0 flush, 1 reset),
  // noise toggles start while the unit is busy.
  task automatic applyStimulus(input int opMode, input int opDst, input int opSrc,
                               input int opImm, input int abortAt, input int abortKind,
                               input bit noise);
    int len;
    bit legal;
    legal = isLegal(opMode, opDst, opSrc);
    len   = legal ? 4 : 3;
    opCount++;
    mode    = 2'(opMode);
    dst_sel = SEL_W'(opDst);
    src_sel = SEL_W'(opSrc);
    imm     = IMM_W'(opImm);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= len; c++) begin
      mode    = 2'($urandom_range(0, 3));
      dst_sel = SEL_W'($urandom);
      src_sel = SEL_W'($urandom);
      imm     = IMM_W'($urandom);
      if (noise && c <= (legal ? 2 : 1)) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (c == abortAt) begin
        if (abortKind == 0) flush = 1'b1;
        else rst = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("op%0d.c%0d", opCount, c), obsVec(),
                  expOut(opMode, opDst, opSrc, opImm, c));
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      rst   = 1'b1;
      if (c == abortAt) begin
        @(negedge clk);
        checkOutput($sformatf("op%0d.abort", opCount), obsVec(), '0);
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  initial begin
    int md, dst, src, iv, ab, kind;
    bit lg;
    rst = 1'b0; flush = 1'b0; start = 1'b1;
    mode = 2'd0; dst_sel = 6'd1; src_sel = 6'd2; imm = 6'h2A;
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset", obsVec(), '0);
    end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    checkOutput("post_reset", obsVec(), '0);
    @(posedge clk); #1;

    applyStimulus(0, 2, 0, 'h2A, 0, 0, 0);
    applyStimulus(1, P0_SEL, 0, 'h3F, 0, 0, 0);
    applyStimulus(1, P0_SEL, 0, 'h1F, 0, 0, 0);
    applyStimulus(2, 0, 3, 0, 0, 0, 0);
    applyStimulus(2, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 7, 0, 5, 0, 0, 0);
    applyStimulus(2, 0, P0_SEL, 0, 0, 0, 0);
    applyStimulus(3, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 9, 1, 0, 0);
    applyStimulus(1, 3, 0, 'h20, 2, 0, 0);
    applyStimulus(0, 3, 0, 'h11, 0, 0, 1);
    applyStimulus(2, 2, 0, 0, 2, 1, 0);

    for (int n = 0; n < 300; n++) begin
      md  = $urandom_range(0, 3);
      dst = $urandom_range(0, 7);
      src = $urandom_range(0, 5);
      iv  = $urandom_range(0, 63);
      lg  = isLegal(md, dst, src);
      ab  = 0;
      kind = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) ab = $urandom_range(1, lg ? 3 : 2);
      applyStimulus(md, dst, src, iv, ab, kind, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
